// File: rtl/fx_mul_pipe.sv
// Two-stage signed Qm.F multiplier: round-half-up, overflow flag and stats; latency 2, one result/cycle.
// Stalls back up from out_ready to in_ready; define FX_MUL_SAT_EN to clamp overflowed results instead of wrapping.
module fx_mul_pipe #(
  parameter int W     = 16,
  parameter int F     = 15,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  input  logic             clr_stats,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [2*W:0]   RND   = {{(2*W){1'b0}}, 1'b1} << (F-1);
  localparam logic [W-1:0]   Y_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   Y_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               s1_vld_q, s1_vld_d;
  logic [2*W-1:0]     s1_p_q, s1_p_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s2_vld_q, s2_vld_d;
  logic [W-1:0]       s2_y_q, s2_y_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
  logic               s2_ovf_q, s2_ovf_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               s1_adv, s2_adv, out_fire;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   sum, r;
  logic [W+1:0]       r_hi;
  logic               ovf_c;
  logic [W-1:0]       y_c;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_vld_q && out_ready;

  // Operands are sign-extended to 2W so the product needs no wider context.
  assign prod = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});

  // One guard bit above the product keeps the rounding add from overflowing.
  assign sum   = $signed({s1_p_q[2*W-1], s1_p_q}) + $signed(RND);
  assign r     = sum >>> F;
  assign r_hi  = r[2*W:W-1];
  assign ovf_c = !((&r_hi) || !(|r_hi));

`ifdef FX_MUL_SAT_EN
  assign y_c = ovf_c ? (r[2*W] ? Y_MIN : Y_MAX) : r[W-1:0];
`else
  assign y_c = r[W-1:0];
`endif

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_p_d   = s1_p_q;
    s1_tag_d = s1_tag_q;
    s2_vld_d = s2_vld_q;
    s2_y_d   = s2_y_q;
    s2_tag_d = s2_tag_q;
    s2_ovf_d = s2_ovf_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    if (s1_adv) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_p_d   = prod;
        s1_tag_d = in_tag;
      end
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_y_d   = y_c;
        s2_tag_d = s1_tag_q;
        s2_ovf_d = ovf_c;
      end
    end

    // Clear takes priority over a coincident counted transfer.
    if (clr_stats) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (out_fire && s2_ovf_q) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_p_q   <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_y_q   <= '0;
      s2_tag_q <= '0;
      s2_ovf_q <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_p_q   <= s1_p_d;
      s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d;
      s2_y_q   <= s2_y_d;
      s2_tag_q <= s2_tag_d;
      s2_ovf_q <= s2_ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_y      = s2_y_q;
  assign out_tag    = s2_tag_q;
  assign out_ovf    = s2_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Randomized and directed bench for fx_mul_pipe against an arithmetic reference model and scoreboard.
module tb_fx_mul_pipe;
  localparam int W     = 16;
  localparam int F     = 15;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, out_ovf, clr_stats, ovf_sticky;
  logic [W-1:0]     in_a, in_b, out_y;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [CNT_W-1:0] ovf_count;

  always #5 clk = ~clk;

  fx_mul_pipe #(.W(W), .F(F), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_ovf(out_ovf),
    .clr_stats(clr_stats), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  typedef struct {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b0;
  logic m_sticky = 1'b0;
  int   m_count = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Exact rational arithmetic: floor((a*b)/2^F + 1/2), then range test.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint p, d, num, r, hi, lo, y;
    p   = longint'($signed(a)) * longint'($signed(b));
    d   = longint'(1) << F;
    num = 2 * p + d;
    d   = 2 * d;
    if (num >= 0) r = num / d;
    else          r = -((-num + d - 1) / d);
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    e.ovf = (r > hi) || (r < lo);
`ifdef FX_MUL_SAT_EN
    y = (r > hi) ? hi : ((r < lo) ? lo : r);
`else
    y = r;
`endif
    e.y   = y[W-1:0];
    e.tag = tag;
    e.cyc = cyc;
    return e;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TAG_W-1:0] tg, input logic ordy, input logic clr);
    logic in_fire, out_fire;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = ordy;
    clr_stats = clr;
    #1;
    in_fire  = in_valid && in_ready && !rst;
    out_fire = out_valid && out_ready && !rst;
    e = '{y: '0, tag: '0, ovf: 1'b0, cyc: 0};
    if (out_fire) begin
      n_out++;
      if (q.size() == 0) chk("spurious_output", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("out_y", 64'(out_y), 64'(e.y));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    if (rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_count  = 0;
    end else if (clr) begin
      m_sticky = 1'b0;
      m_count  = 0;
    end else if (out_fire && e.ovf) begin
      m_sticky = 1'b1;
      if (m_count < CNT_MAX) m_count++;
    end
    if (in_fire) begin
      q.push_back(model(a, b, tg));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    chk("ovf_count", 64'(ovf_count), 64'(m_count));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0001;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [W-1:0] dir_a [6] = '{16'h4000, 16'h7FFF, 16'hC000, 16'h7FFF, 16'h8000, 16'h8000};
  logic [W-1:0] dir_b [6] = '{16'h4000, 16'h4000, 16'h4000, 16'h7FFF, 16'h8000, 16'h7FFF};

  initial begin
    int acc0, out0;
    logic [W-1:0] y_hold;
    logic [TAG_W-1:0] t_hold;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_count", 64'(ovf_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, including rounding and the single overflowing corner.
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, dir_a[i], dir_b[i], TAG_W'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Back-to-back stream: eight results, one per cycle, tags in order.
    out0 = n_out;
    for (int i = 0; i < 8; i++) step(1'b1, pick(), pick(), TAG_W'(i), 1'b1, 1'b0);
    chk("stream_rate", 64'(n_out - out0), 64'd6);
    repeat (2) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("stream_total", 64'(n_out - out0), 64'd8);
    chk_lat = 1'b0;

    // Stall: exactly two entries fit, output held stable.
    acc0 = n_acc;
    y_hold = '0; t_hold = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pick(), pick(), TAG_W'(8 + i), 1'b0, 1'b0);
      if (i == 2) begin y_hold = out_y; t_hold = out_tag; end
    end
    chk("stall_accepted", 64'(n_acc - acc0), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_y_stable", 64'(out_y), 64'(y_hold));
    chk("stall_tag_stable", 64'(out_tag), 64'(t_hold));
    step(1'b1, pick(), pick(), TAG_W'(12), 1'b1, 1'b0);
    chk("release_accept", 64'(n_acc - acc0), 64'd3);
    repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Counter saturation and clear-wins-over-count.
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h8000, 16'h8000, TAG_W'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("count_saturated", 64'(ovf_count), 64'(CNT_MAX));
    step(1'b1, 16'h8000, 16'h8000, 4'd5, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("ovf6_waiting", 64'(out_valid), 64'd1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("clr_wins_count", 64'(ovf_count), 64'd0);
    chk("clr_wins_sticky", 64'(ovf_sticky), 64'd0);

    // Random traffic with bubbles, stalls and occasional clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, pick(), pick(), TAG_W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    // Reset with two samples in flight (and whatever stats accrued).
    step(1'b1, 16'h8000, 16'h8000, 4'd1, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 16'h8000, 4'd2, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("no_stale_valid", 64'(out_valid), 64'd0);
    end
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
